tinycore_fetch: RTL and testbench

Instruction fetch stage for the tinycore CPU. Reads two consecutive bytes per instruction from the single-port, 1-cycle-latency program memory and assembles a 16-bit instruction word with its PC. Hands the word to the execute stage over a valid/ready handshake, and restarts at a new PC when execute signals a taken branch or jump.

---
 rtl/tinycore_pkg.sv | 28 ++
 rtl/tinycore_fetch_buf.sv | 42 ++++
 rtl/tinycore_fetch.sv | 203 ++++++++++++++++++++
 tb/tb_tinycore_fetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tinycore_pkg.sv
// Shared tinycore definitions: fetch FSM state encoding, instruction width
// and instruction field positions used by both fetch and execute.
package tinycore_pkg;

  typedef enum logic [1:0] {
    S_REQ_HI = 2'd0,
    S_REQ_LO = 2'd1,
    S_CAP    = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam int DATA_SZ_DEF = 8;
  localparam int INSTR_SZ    = 2 * DATA_SZ_DEF;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;

  function automatic logic [3:0] opcode_of(input logic [INSTR_SZ-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [3:0] rd_of(input logic [INSTR_SZ-1:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/tinycore_fetch_buf.sv
// One-entry skid buffer with valid/ready on both sides; only exists when
// TINYCORE_FETCH_PREFETCH_EN is defined. A push and a pop may share a cycle.
`ifdef TINYCORE_FETCH_PREFETCH_EN
module tinycore_fetch_buf #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_full;
  logic [W-1:0] r_data;
  logic         w_push;

  assign in_ready  = !r_full | out_ready;
  assign w_push    = in_valid & in_ready;
  assign out_valid = r_full;
  assign out_data  = r_data;

  always_ff @(posedge clk) begin
    if (reset | flush)
      r_full <= 1'b0;
    else if (w_push)
      r_full <= 1'b1;
    else if (out_ready)
      r_full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_data <= in_data;
  end

endmodule
`endif

// File: rtl/tinycore_fetch.sv
// tinycore fetch stage: two byte reads per instruction, valid/ready hand-off,
// redirect flush. TINYCORE_FETCH_PREFETCH_EN adds a one-entry prefetch buffer.
module tinycore_fetch
  import tinycore_pkg::*;
#(
  parameter int                 ADDR_SZ  = 8,
  parameter int                 DATA_SZ  = 8,
  parameter logic [ADDR_SZ-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SZ-1:0]   data_i,
  output logic [ADDR_SZ-1:0]   addr,
  output logic [2*DATA_SZ-1:0] instr_o,
  output logic [ADDR_SZ-1:0]   instr_pc_o,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  input  logic                 redirect_i,
  input  logic [ADDR_SZ-1:0]   redirect_pc_i
);

  localparam int IW = 2 * DATA_SZ;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_SZ-1:0] r_pc;
  logic [DATA_SZ-1:0] r_hi;
  logic [IW-1:0]      r_instr;
  logic [ADDR_SZ-1:0] r_ipc;
  logic               r_valid;
  logic               w_pc_inc;
  logic               w_hi_load;
  logic               w_cap;
  logic               w_accept;
  logic [IW-1:0]      w_word;
  logic [ADDR_SZ-1:0] w_word_pc;

  assign addr          = r_pc;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_ipc;
  assign instr_valid_o = r_valid;

  assign w_accept  = r_valid & instr_ready_i;
  assign w_cap     = (r_state == S_CAP);
  assign w_word    = {r_hi, data_i};
  // pc has already stepped past both bytes when the low byte lands
  assign w_word_pc = r_pc - ADDR_SZ'(2);

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_REQ_HI;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_pc <= RESET_PC;
    else if (redirect_i)
      r_pc <= redirect_pc_i;
    else if (w_pc_inc)
      r_pc <= r_pc + ADDR_SZ'(1);
  end

  always_ff @(posedge clk) begin
    if (w_hi_load)
      r_hi <= data_i;
  end

`ifdef TINYCORE_FETCH_PREFETCH_EN
  logic                    w_buf_vld;
  logic                    w_buf_in_rdy;
  logic                    w_out_load;
  logic                    w_direct;
  logic                    w_word_taken;
  logic                    w_start;
  logic [1:0]              w_cnt_after;
  logic [IW+ADDR_SZ-1:0]   w_buf_dout;

  assign w_out_load   = !r_valid | w_accept;
  assign w_direct     = w_cap & w_out_load & !w_buf_vld;
  assign w_word_taken = w_direct | w_buf_in_rdy;
  // A new fetch may start only if a slot is guaranteed when its word lands
  assign w_cnt_after  = 2'(r_valid) + 2'(w_buf_vld) + 2'(w_cap) - 2'(w_accept);
  assign w_start      = (w_cnt_after < 2'd2);

  tinycore_fetch_buf #(
    .W(IW + ADDR_SZ)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_i),
    .in_valid (w_cap & !w_direct),
    .in_ready (w_buf_in_rdy),
    .in_data  ({w_word, w_word_pc}),
    .out_valid(w_buf_vld),
    .out_ready(w_out_load),
    .out_data (w_buf_dout)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_i) begin
      w_state_nxt = S_REQ_HI;
    end else begin
      case (r_state)
        S_REQ_HI: if (w_start) w_state_nxt = S_REQ_LO;
        S_REQ_LO: w_state_nxt = S_CAP;
        S_CAP: begin
          if (!w_word_taken)
            w_state_nxt = S_CAP;
          else if (w_start)
            w_state_nxt = S_REQ_LO;
          else
            w_state_nxt = S_REQ_HI;
        end
        default:  w_state_nxt = S_REQ_HI;
      endcase
    end
  end

  // S_CAP doubles as the next instruction's S_REQ_HI when a slot is free
  always_comb begin
    w_pc_inc  = 1'b0;
    w_hi_load = 1'b0;
    case (r_state)
      S_REQ_HI: w_pc_inc = w_start;
      S_REQ_LO: begin
        w_pc_inc  = 1'b1;
        w_hi_load = 1'b1;
      end
      S_CAP:    w_pc_inc = w_start & w_word_taken;
      default:  w_pc_inc = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_ipc   <= '0;
    end else if (redirect_i) begin
      r_valid <= 1'b0;
    end else if (w_out_load) begin
      if (w_buf_vld) begin
        {r_instr, r_ipc} <= w_buf_dout;
        r_valid          <= 1'b1;
      end else if (w_cap) begin
        r_instr <= w_word;
        r_ipc   <= w_word_pc;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end
`else
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_i) begin
      w_state_nxt = S_REQ_HI;
    end else begin
      case (r_state)
        S_REQ_HI: w_state_nxt = S_REQ_LO;
        S_REQ_LO: w_state_nxt = S_CAP;
        S_CAP:    w_state_nxt = S_HOLD;
        S_HOLD:   if (w_accept) w_state_nxt = S_REQ_HI;
        default:  w_state_nxt = S_REQ_HI;
      endcase
    end
  end

  always_comb begin
    w_pc_inc  = 1'b0;
    w_hi_load = 1'b0;
    case (r_state)
      S_REQ_HI: w_pc_inc = 1'b1;
      S_REQ_LO: begin
        w_pc_inc  = 1'b1;
        w_hi_load = 1'b1;
      end
      default:  w_pc_inc = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_ipc   <= '0;
    end else if (redirect_i) begin
      r_valid <= 1'b0;
    end else if (w_cap) begin
      r_instr <= w_word;
      r_ipc   <= w_word_pc;
      r_valid <= 1'b1;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_tinycore_fetch.sv
// Scoreboard bench for tinycore_fetch: the stimulus side queues the expected
// instruction stream on every reset/redirect, a monitor checks each accept.
module tb_tinycore_fetch;

`ifdef TINYCORE_FETCH_PREFETCH_EN
  localparam int PER = 2;
`else
  localparam int PER = 4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_i;
  logic [7:0]  addr;
  logic [15:0] instr_o;
  logic [7:0]  instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [7:0]  redirect_pc_i;

  always #5 clk = ~clk;

  tinycore_fetch #(
    .ADDR_SZ (8),
    .DATA_SZ (8),
    .RESET_PC(8'h00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_i       (data_i),
    .addr         (addr),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i)
  );

  // Program memory: one-cycle read latency
  logic [7:0] mem [256];
  always @(posedge clk) data_i <= mem[addr];

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors  = 0;
  int   checks  = 0;
  int   accepts = 0;

  function automatic logic [15:0] ref_word(input logic [7:0] pc);
    logic [7:0] lo;
    lo = pc + 8'd1;
    return {mem[pc], mem[lo]};
  endfunction

  // Instructions run sequentially (mod 256) from a restart point
  task automatic start_stream(input logic [7:0] pc0);
    sb_q.delete();
    for (int i = 0; i < 128; i++) begin
      logic [7:0] p;
      p = pc0 + 8'(2 * i);
      sb_q.push_back('{pc: p, instr: ref_word(p)});
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, input string name);
    int n;
    n = 0;
    while (!instr_valid_o && n < max) begin
      tick();
      n++;
    end
    if (!instr_valid_o) begin
      checks++;
      errors++;
      $display("FAIL %s: valid not seen within %0d cycles", name, max);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && !redirect_i && instr_valid_o && instr_ready_i) begin
      accepts++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got pc %0h with nothing expected", instr_pc_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_pc", 32'(instr_pc_o), 32'(mon_e.pc));
        chk("sb_instr", 32'(instr_o), 32'(mon_e.instr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int v2, v3;
    logic [7:0] tgt;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h12;
    mem[8'h01] = 8'h34;
    mem[8'hFF] = 8'hAB;

    reset         = 1'b1;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 8'h00;
    repeat (3) tick();
    chk("reset_addr", 32'(addr), 32'h00);
    chk("reset_valid", 32'(instr_valid_o), 32'h0);
    chk("reset_instr", 32'(instr_o), 32'h0);
    chk("reset_ipc", 32'(instr_pc_o), 32'h0);

    // Reset release and first-instruction latency
    instr_ready_i = 1'b1;
    start_stream(8'h00);
    reset = 1'b0;
    chk("addr_t0", 32'(addr), 32'h00);
    tick();
    chk("addr_t1", 32'(addr), 32'h01);
    chk("valid_t1", 32'(instr_valid_o), 32'h0);
    tick();
    chk("valid_t2", 32'(instr_valid_o), 32'h0);
    tick();
    chk("valid_t3", 32'(instr_valid_o), 32'h1);
    chk("instr_t3", 32'(instr_o), 32'h1234);
    chk("pc_t3", 32'(instr_pc_o), 32'h00);

    v2 = -1;
    v3 = -1;
    for (int k = 3; k <= 12; k++) begin
      tick();
      if (instr_valid_o) begin
        if (v2 < 0) v2 = k;
        else if (v3 < 0) v3 = k;
      end
    end
    chk("cadence_2nd", 32'(v2), 32'(2 + PER));
    chk("cadence_3rd", 32'(v3), 32'(2 + 2 * PER));

    // Backpressure
    reset         = 1'b1;
    instr_ready_i = 1'b0;
    repeat (2) tick();
    start_stream(8'h00);
    reset = 1'b0;
    wait_valid(10, "bp_wait");
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(instr_valid_o), 32'h1);
      chk("bp_instr", 32'(instr_o), 32'(sb_q[0].instr));
      chk("bp_pc", 32'(instr_pc_o), 32'(sb_q[0].pc));
      tick();
    end
    instr_ready_i = 1'b1;
    tick();
    wait_valid(10, "bp_next_wait");
    chk("bp_next_pc", 32'(instr_pc_o), 32'h02);

    // Redirect coinciding with an accept
    wait_valid(10, "rd_wait");
    redirect_i    = 1'b1;
    redirect_pc_i = 8'h40;
    start_stream(8'h40);
    tick();
    redirect_i = 1'b0;
    chk("rd_valid_drop", 32'(instr_valid_o), 32'h0);
    chk("rd_addr", 32'(addr), 32'h40);
    tick();
    chk("rd_valid_r1", 32'(instr_valid_o), 32'h0);
    tick();
    chk("rd_valid_r2", 32'(instr_valid_o), 32'h0);
    tick();
    chk("rd_valid_r3", 32'(instr_valid_o), 32'h1);
    chk("rd_pc", 32'(instr_pc_o), 32'h40);
    chk("rd_instr", 32'(instr_o), 32'(ref_word(8'h40)));

    // Address wrap
    mem[8'h00]    = 8'hCD;
    redirect_i    = 1'b1;
    redirect_pc_i = 8'hFF;
    start_stream(8'hFF);
    tick();
    redirect_i = 1'b0;
    repeat (3) tick();
    chk("wrap_valid", 32'(instr_valid_o), 32'h1);
    chk("wrap_instr", 32'(instr_o), 32'hABCD);
    chk("wrap_pc", 32'(instr_pc_o), 32'hFF);
    tick();
    wait_valid(10, "wrap_next_wait");
    chk("wrap_next_pc", 32'(instr_pc_o), 32'h01);

    // Random ready and redirects, checked by the scoreboard
    for (int c = 0; c < 300; c++) begin
      instr_ready_i = (($urandom % 4) != 0);
      if (($urandom % 24) == 0) begin
        tgt           = 8'($urandom);
        redirect_i    = 1'b1;
        redirect_pc_i = tgt;
        start_stream(tgt);
      end else begin
        redirect_i = 1'b0;
      end
      tick();
    end
    redirect_i = 1'b0;

    // Reset while the low byte is being requested
    instr_ready_i = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 8'h80;
    start_stream(8'h80);
    tick();
    redirect_i = 1'b0;
    tick();
    reset = 1'b1;
    start_stream(8'h00);
    tick();
    chk("rm_valid", 32'(instr_valid_o), 32'h0);
    chk("rm_addr", 32'(addr), 32'h00);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rm_valid_t3", 32'(instr_valid_o), 32'h1);
    chk("rm_pc", 32'(instr_pc_o), 32'h00);
    chk("rm_instr", 32'(instr_o), 32'(ref_word(8'h00)));
    repeat (10) tick();

    chk("accepts_seen", 32'(accepts > 20), 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
